// File: rtl/minibyte_ctrl_unit_if.sv
// Control bundle between the minibyte sequencer and its datapath.
// The master side is the sequencer. The slave side is the datapath/memory.
interface minibyte_ctrl_unit_if;
    logic [7:0] data_in;
    logic       zero_in;
    logic       ctrl_set_a;
    logic       ctrl_set_m;
    logic       ctrl_set_pc;
    logic       ctrl_inc_pc;
    logic       addr_sel_out;
    logic [1:0] bus_sel_out;
    logic [2:0] alu_op_out;
    logic       we_out;
    logic       halted_out;
    logic       illegal_out;

    modport master (
        input  data_in, zero_in,
        output ctrl_set_a, ctrl_set_m, ctrl_set_pc, ctrl_inc_pc,
               addr_sel_out, bus_sel_out, alu_op_out, we_out,
               halted_out, illegal_out
    );

    modport slave (
        output data_in, zero_in,
        input  ctrl_set_a, ctrl_set_m, ctrl_set_pc, ctrl_inc_pc,
               addr_sel_out, bus_sel_out, alu_op_out, we_out,
               halted_out, illegal_out
    );
endinterface

// File: rtl/minibyte_ctrl_unit.sv
// Minibyte instruction sequencer: a fetch/decode/exec Moore FSM that drives the datapath strobes.
// Optional MINIBYTE_ILLEGAL_TRAP_EN: an undefined opcode halts the core and raises illegal_out.
module minibyte_ctrl_unit #(
    parameter logic [7:0] IR_RESET = 8'h00
) (
    input logic                  clk_in,
    input logic                  rst_in,
    minibyte_ctrl_unit_if.master bus
);
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IR_W    = 8;

    localparam logic [STATE_W-1:0] S_RST    = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd4;

    localparam logic [IR_W-1:0] OP_NOP = 8'h00;
    localparam logic [IR_W-1:0] OP_LDI = 8'h01;
    localparam logic [IR_W-1:0] OP_LDM = 8'h02;
    localparam logic [IR_W-1:0] OP_LDA = 8'h03;
    localparam logic [IR_W-1:0] OP_STA = 8'h04;
    localparam logic [IR_W-1:0] OP_JMP = 8'h05;
    localparam logic [IR_W-1:0] OP_BZ  = 8'h06;
    localparam logic [IR_W-1:0] OP_HLT = 8'hFF;

    localparam logic [1:0] BUS_DATA = 2'd0;
    localparam logic [1:0] BUS_ALU  = 2'd1;
    localparam logic [1:0] BUS_A    = 2'd2;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [IR_W-1:0]    ir;
    logic               op_alu;
    logic               op_known;

    // Opcodes that take an execute cycle; 8'h10-8'h13 form the ALU group.
    assign op_alu   = (ir[7:2] == 6'b000100);
    assign op_known = op_alu || ((ir >= OP_LDI) && (ir <= OP_BZ));

    // State and instruction register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= S_RST;
            ir    <= IR_RESET;
        end else begin
            state <= next_state;
            if (state == S_FETCH) begin
                ir <= bus.data_in;
            end
        end
    end

    // Next-state and strobe decode from state and IR only (zero_in steers BZ).
    always_comb begin
        next_state       = state;
        bus.ctrl_set_a   = 1'b0;
        bus.ctrl_set_m   = 1'b0;
        bus.ctrl_set_pc  = 1'b0;
        bus.ctrl_inc_pc  = 1'b0;
        bus.addr_sel_out = 1'b0;
        bus.bus_sel_out  = BUS_DATA;
        bus.alu_op_out   = 3'd0;
        bus.we_out       = 1'b0;
        bus.halted_out   = 1'b0;
        bus.illegal_out  = 1'b0;

        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                bus.ctrl_inc_pc = 1'b1;
                next_state      = S_DECODE;
            end
            S_DECODE: begin
                if (ir == OP_HLT) begin
                    next_state = S_HALT;
                end else if (op_known) begin
                    next_state = S_EXEC;
                end else if (ir == OP_NOP) begin
                    next_state = S_FETCH;
                end else begin
`ifdef MINIBYTE_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                if (op_alu) begin
                    bus.addr_sel_out = 1'b1;
                    bus.bus_sel_out  = BUS_ALU;
                    bus.alu_op_out   = {1'b0, ir[1:0]};
                    bus.ctrl_set_a   = 1'b1;
                end else begin
                    case (ir)
                        OP_LDI: begin
                            bus.ctrl_set_a  = 1'b1;
                            bus.ctrl_inc_pc = 1'b1;
                        end
                        OP_LDM: begin
                            bus.ctrl_set_m  = 1'b1;
                            bus.ctrl_inc_pc = 1'b1;
                        end
                        OP_LDA: begin
                            bus.addr_sel_out = 1'b1;
                            bus.ctrl_set_a   = 1'b1;
                        end
                        OP_STA: begin
                            bus.addr_sel_out = 1'b1;
                            bus.bus_sel_out  = BUS_A;
                            bus.we_out       = 1'b1;
                        end
                        OP_JMP: bus.ctrl_set_pc = 1'b1;
                        // Not-taken branch steps the PC over the target operand.
                        OP_BZ: begin
                            bus.ctrl_set_pc = bus.zero_in;
                            bus.ctrl_inc_pc = !bus.zero_in;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                bus.halted_out = 1'b1;
`ifdef MINIBYTE_ILLEGAL_TRAP_EN
                bus.illegal_out = (ir != OP_HLT);
`endif
            end
            default: next_state = S_RST;
        endcase
    end
endmodule

// File: tb/tb_minibyte_ctrl_unit.sv
// Directed bench for minibyte_ctrl_unit with a small PC/M/memory model around it.
module tb_minibyte_ctrl_unit;
    logic       clk;
    logic       rst_n;
    logic       zero;
    logic [7:0] mem [256];
    logic [7:0] pc;
    logic [7:0] m;
    logic [7:0] addr;
    int         n_tests;
    int         n_fail;

    minibyte_ctrl_unit_if bus_if ();

    minibyte_ctrl_unit #(.IR_RESET(8'h00)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign addr           = bus_if.addr_sel_out ? m : pc;
    assign bus_if.data_in = mem[addr];
    assign bus_if.zero_in = zero;

    // PC and M registers of the datapath; loads only take the memory bus source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 8'h00;
            m  <= 8'h00;
        end else begin
            if (bus_if.ctrl_set_pc) pc <= bus_if.data_in;
            else if (bus_if.ctrl_inc_pc) pc <= pc + 8'h01;
            if (bus_if.ctrl_set_m) m <= bus_if.data_in;
        end
    end

    logic [12:0] outs;
    assign outs = {bus_if.ctrl_set_a, bus_if.ctrl_set_m, bus_if.ctrl_set_pc, bus_if.ctrl_inc_pc,
                   bus_if.addr_sel_out, bus_if.bus_sel_out, bus_if.alu_op_out, bus_if.we_out,
                   bus_if.halted_out, bus_if.illegal_out};

    function automatic logic [12:0] ov(input logic sa, input logic sm, input logic sp,
                                       input logic ip, input logic as, input logic [1:0] bs,
                                       input logic [2:0] ao, input logic we, input logic h,
                                       input logic il);
        return {sa, sm, sp, ip, as, bs, ao, we, h, il};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first S_FETCH cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_val(tag, 32'(outs), 32'(13'h0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    logic [12:0] v_fetch, v_idle, v_ldi, v_ldm, v_sta, v_jmp, v_bznt, v_alu11, v_halt, v_trap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        zero    = 1'b0;
        rst_n   = 1'b0;
        v_fetch = ov(0, 0, 0, 1, 0, 2'd0, 3'd0, 0, 0, 0);
        v_idle  = ov(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
        v_ldi   = ov(1, 0, 0, 1, 0, 2'd0, 3'd0, 0, 0, 0);
        v_ldm   = ov(0, 1, 0, 1, 0, 2'd0, 3'd0, 0, 0, 0);
        v_sta   = ov(0, 0, 0, 0, 1, 2'd2, 3'd0, 1, 0, 0);
        v_jmp   = ov(0, 0, 1, 0, 0, 2'd0, 3'd0, 0, 0, 0);
        v_bznt  = ov(0, 0, 0, 1, 0, 2'd0, 3'd0, 0, 0, 0);
        v_alu11 = ov(1, 0, 0, 0, 1, 2'd1, 3'd1, 0, 0, 0);
        v_halt  = ov(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 0);
        v_trap  = ov(0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 1, 1);

        // All-NOP memory: fetch/decode alternate, PC advances by one per pair.
        clear_mem();
        do_reset("rst_init");
        for (int c = 1; c <= 6; c++) begin
            check_val($sformatf("nop_c%0d", c), 32'(outs), 32'((c % 2 == 1) ? v_fetch : v_idle));
            tick();
        end
        check_val("nop_pc", 32'(pc), 32'(8'h03));

        // LDI 5A, LDM 80, STA.
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h5A; mem[2] = 8'h02; mem[3] = 8'h80; mem[4] = 8'h04;
        do_reset("rst_prog");
        check_val("prog_c1", 32'(outs), 32'(v_fetch)); tick();
        check_val("prog_c2", 32'(outs), 32'(v_idle));  tick();
        check_val("ldi_c3",  32'(outs), 32'(v_ldi));   tick();
        check_val("prog_c4", 32'(outs), 32'(v_fetch)); tick();
        check_val("prog_c5", 32'(outs), 32'(v_idle));  tick();
        check_val("ldm_c6",  32'(outs), 32'(v_ldm));   tick();
        check_val("ldm_m",   32'(m),    32'(8'h80));
        check_val("prog_c7", 32'(outs), 32'(v_fetch)); tick();
        tick();
        check_val("sta_c9",  32'(outs), 32'(v_sta));   tick();
        check_val("sta_next_pc", 32'(pc), 32'(8'h05));

        // BZ taken.
        clear_mem();
        mem[0] = 8'h06; mem[1] = 8'h20;
        zero = 1'b1;
        do_reset("rst_bz1");
        tick(); tick();
        check_val("bz_taken", 32'(outs), 32'(v_jmp)); tick();
        check_val("bz_taken_pc", 32'(pc), 32'(8'h20));
        check_val("bz_taken_fetch", 32'(outs), 32'(v_fetch));

        // BZ not taken: next fetch at opcode address + 2.
        zero = 1'b0;
        do_reset("rst_bz0");
        tick(); tick();
        check_val("bz_not_taken", 32'(outs), 32'(v_bznt)); tick();
        check_val("bz_not_taken_pc", 32'(pc), 32'(8'h02));

        // ALU op 8'h11 (SUB).
        clear_mem();
        mem[0] = 8'h11;
        do_reset("rst_alu");
        tick(); tick();
        check_val("alu_sub", 32'(outs), 32'(v_alu11)); tick();
        check_val("alu_next", 32'(outs), 32'(v_fetch));

        // HLT holds, then reset drops halted_out without a clock edge.
        clear_mem();
        mem[0] = 8'hFF;
        do_reset("rst_hlt");
        tick();
        check_val("hlt_decode", 32'(outs), 32'(v_idle)); tick();
        for (int c = 0; c < 20; c++) begin
            check_val($sformatf("hlt_hold%0d", c), 32'(outs), 32'(v_halt));
            tick();
        end
        #2;
        do_reset("hlt_async_rst");

        // Reset during LDI execute drops strobes immediately.
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h33;
        do_reset("rst_ldi");
        tick(); tick();
        check_val("ldi_before_rst", 32'(outs), 32'(v_ldi));
        do_reset("ldi_mid_rst");
        check_val("ldi_mid_rst_pc", 32'(pc), 32'(8'h00));

        // Undefined opcode.
        clear_mem();
        mem[0] = 8'h7E;
        do_reset("rst_ill");
        tick(); tick();
`ifdef MINIBYTE_ILLEGAL_TRAP_EN
        check_val("ill_trap", 32'(outs), 32'(v_trap)); tick(); tick();
        check_val("ill_trap_hold", 32'(outs), 32'(v_trap));
`else
        check_val("ill_as_nop", 32'(outs), 32'(v_fetch));
        check_val("ill_as_nop_pc", 32'(pc), 32'(8'h01));
        check_val("ill_flag_low", 32'(bus_if.illegal_out), 32'(1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/minibyte_ctrl_unit.md
Name: minibyte_ctrl_unit

Overview:
- Instruction sequencer for the minibyte CPU datapath (A, M and PC registers, main bus, address mux, ALU).
- Fetches an opcode byte from memory into an internal IR.
- Decodes it and drives the register set/increment strobes, bus source select, address select, ALU op and memory write-enable.
- Multi-cycle Moore FSM: every instruction takes 2 or 3 clocks.

Parameters:
- IR_RESET, 8'h00, IR value loaded on reset (decodes as NOP).

Ports:
- clk_in  input  1  system clock, all state changes on rising edge
- rst_in  input  1  asynchronous, active-low reset
- data_in  input  8  memory read data (opcode or operand)
- zero_in  input  1  A-register-is-zero flag from the datapath, combinational
- ctrl_set_a  output  1  load A from main bus
- ctrl_set_m  output  1  load M from main bus
- ctrl_set_pc  output  1  load PC from main bus
- ctrl_inc_pc  output  1  PC <= PC+1, wrapping 8'hFF to 8'h00
- addr_sel_out  output  1  0 = PC drives addr_out, 1 = M drives addr_out
- bus_sel_out  output  2  main bus source: 0 data_in, 1 ALU result, 2 A register, 3 reserved
- alu_op_out  output  3  0 ADD, 1 SUB, 2 AND, 3 OR
- we_out  output  1  memory write strobe, one cycle
- halted_out  output  1  core halted
- illegal_out  output  1  undefined opcode trapped

Behaviour:
- States: S_RST, S_FETCH, S_DECODE, S_EXEC, S_HALT. State register and IR are the only flops.
- All outputs decode from state and IR only. zero_in is used only in S_EXEC of BZ.
- Reset (rst_in=0, async):
  - state=S_RST, IR=IR_RESET.
  - In S_RST every output is 0, including addr_sel_out, bus_sel_out and alu_op_out.
  - S_RST -> S_FETCH on the first clock after release.
- S_FETCH:
  - addr_sel=0, ctrl_inc_pc=1.
  - IR <= data_in.
  - -> S_DECODE.
- S_DECODE:
  - No strobes asserted.
  - NOP (8'h00) or undefined opcode -> S_FETCH.
  - HLT (8'hFF) -> S_HALT.
  - Any other opcode -> S_EXEC.
- S_EXEC, then -> S_FETCH:
  - 8'h01 LDI: addr_sel=0, bus_sel=0, ctrl_set_a=1, ctrl_inc_pc=1.
  - 8'h02 LDM: addr_sel=0, bus_sel=0, ctrl_set_m=1, ctrl_inc_pc=1.
  - 8'h03 LDA: addr_sel=1, bus_sel=0, ctrl_set_a=1.
  - 8'h04 STA: addr_sel=1, bus_sel=2, we_out=1.
  - 8'h05 JMP: addr_sel=0, bus_sel=0, ctrl_set_pc=1.
  - 8'h06 BZ, zero_in=1: same as JMP.
  - 8'h06 BZ, zero_in=0: ctrl_inc_pc=1 only, skipping the operand.
  - 8'h10-8'h13 ALU: addr_sel=1, bus_sel=1, alu_op=IR[1:0], ctrl_set_a=1.
- S_HALT:
  - halted_out=1, all strobes 0.
  - Stays until reset.
- Latency: NOP 2 clocks; LDI, LDM, LDA, STA, JMP, BZ and ALU ops 3 clocks.
- Strobe exclusivity: ctrl_set_pc and ctrl_inc_pc are never asserted in the same cycle. At most one of ctrl_set_a, ctrl_set_m, ctrl_set_pc, we_out is high per cycle.
- PC wrap is the PC register's job. A fetch at 8'hFF followed by inc gives PC=8'h00 and is legal.
- Reset mid-instruction: immediate return to S_RST; strobes drop the same instant, and no partial write or register load completes.

Optional Feature:
- Macro MINIBYTE_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined opcode in S_DECODE goes to S_HALT.
  - illegal_out=1 and halted_out=1 until reset.
- Undefined:
  - Undefined opcodes execute as NOP (2 clocks).
  - illegal_out is tied 0.

Test Plan:
- Reset release, memory returns 8'h00 at every address -> S_FETCH one clock after release; ctrl_inc_pc pulses every 2nd clock; no other strobe ever high.
- Program 01 5A, 02 80, 04 -> LDI: ctrl_set_a with bus_sel=0 at cycle 3; LDM: ctrl_set_m at cycle 6; STA: we_out=1, addr_sel=1, bus_sel=2 at cycle 9.
- 8'h06 with zero_in=1 -> ctrl_set_pc in S_EXEC. Repeat with zero_in=0 -> ctrl_inc_pc only, and the next fetch is at the opcode address +2.
- 8'h11 -> in S_EXEC: alu_op_out=1, bus_sel=1, addr_sel=1, ctrl_set_a=1.
- 8'hFF -> halted_out=1 from the cycle after S_DECODE and stays 1 for 20 clocks; assert rst_in=0 mid-halt -> halted_out=0 asynchronously.
- 8'h7E -> with MINIBYTE_ILLEGAL_TRAP_EN: illegal_out=1 and halted_out=1; without it: treated as NOP, next fetch after 2 clocks, illegal_out=0.
